// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed scan controller for a multi-digit
// seven-segment display. One nibble at a time is presented on DisVal while
// the matching active-low anode is driven. Display data is double-buffered
// and only swapped at frame boundaries, so a new value never tears mid-frame.
`timescale 1ns/1ps

module seven_seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DEAD        = 4
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic [4*NUM_DIGITS-1:0]   DataIn,
    input  logic                      DataLoad,
    input  logic [NUM_DIGITS-1:0]     BlankMask,
    output logic [3:0]                DisVal,
    output logic [NUM_DIGITS-1:0]     AnOut,
    output logic                      FrameDone,
    output logic                      Pending
);

    localparam int unsigned DATA_W = 4 * NUM_DIGITS;
    localparam int unsigned DIV_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Scan state
    logic [DIV_W-1:0]      div;
    logic [DIV_W-1:0]      divNext;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idxNext;

    // Double buffer
    logic [DATA_W-1:0]     pendReg;
    logic [DATA_W-1:0]     pendRegNext;
    logic                  pendFlag;
    logic                  pendFlagNext;
    logic [DATA_W-1:0]     showReg;
    logic [DATA_W-1:0]     showRegNext;

    // Decoded events and next output values
    logic                  slotTick;
    logic                  frameEdge;
    logic [3:0]            disValNext;
    logic [NUM_DIGITS-1:0] anOutNext;

    // Slot and frame boundary detection from the current scan position
    always_comb begin
        slotTick  = (div == DIV_W'(REFRESH_DIV - 1));
        frameEdge = slotTick && (idx == IDX_W'(NUM_DIGITS - 1));
    end

    // Prescaler and digit index advance; index wraps on the frame boundary
    always_comb begin
        divNext = div + DIV_W'(1);
        idxNext = idx;
        if (slotTick) begin
            divNext = '0;
            if (frameEdge) begin
                idxNext = '0;
            end else begin
                idxNext = idx + IDX_W'(1);
            end
        end
    end

    // Buffer update: a load on the boundary bypasses the pending buffer
    always_comb begin
        pendRegNext  = pendReg;
        pendFlagNext = pendFlag;
        showRegNext  = showReg;
        if (frameEdge) begin
            if (DataLoad) begin
                showRegNext = DataIn;
            end else if (pendFlag) begin
                showRegNext = pendReg;
            end
            pendFlagNext = 1'b0;
        end else if (DataLoad) begin
            pendRegNext  = DataIn;
            pendFlagNext = 1'b1;
        end
    end

    // Digit mux and anode decode; anode stays dark during the dead period
    always_comb begin
        disValNext = '0;
        anOutNext  = '1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx == IDX_W'(i)) begin
                disValNext = showReg[4*i +: 4];
                if ((div >= DIV_W'(DEAD)) && !BlankMask[i]) begin
                    anOutNext[i] = 1'b0;
                end
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            div       <= '0;
            idx       <= '0;
            pendReg   <= '0;
            pendFlag  <= 1'b0;
            showReg   <= '0;
            DisVal    <= '0;
            AnOut     <= '1;
            FrameDone <= 1'b0;
        end else begin
            div       <= divNext;
            idx       <= idxNext;
            pendReg   <= pendRegNext;
            pendFlag  <= pendFlagNext;
            showReg   <= showRegNext;
            DisVal    <= disValNext;
            AnOut     <= anOutNext;
            FrameDone <= frameEdge;
        end
    end

    // Pending mirrors the flag register directly
    assign Pending = pendFlag;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed plus random stimulus against a
// position-in-frame reference model (cycle count -> digit/slot offset).
`timescale 1ns/1ps

module tb_seven_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int RD    = 8;
    localparam int DEADC = 2;
    localparam int FRAME = ND * RD;

    logic        Clk;
    logic        Rst;
    logic [15:0] DataIn;
    logic        DataLoad;
    logic [3:0]  BlankMask;
    logic [3:0]  DisVal;
    logic [3:0]  AnOut;
    logic        FrameDone;
    logic        Pending;

    seven_seg_scan_ctrl #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD),
        .DEAD       (DEADC)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .DataIn   (DataIn),
        .DataLoad (DataLoad),
        .BlankMask(BlankMask),
        .DisVal   (DisVal),
        .AnOut    (AnOut),
        .FrameDone(FrameDone),
        .Pending  (Pending)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: cycles since reset release, shown/pending values
    int          cyc;
    logic [15:0] showM;
    logic [15:0] pendM;
    bit          pendFM;
    logic [3:0]  mask;

    int assertCount;
    int failCount;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s observed=%h expected=%h at cyc %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic modelReset();
        cyc    = 0;
        showM  = '0;
        pendM  = '0;
        pendFM = 1'b0;
    endtask

    // One clock: drive inputs, advance model, compare all outputs
    task automatic tick(input bit ld, input logic [15:0] d);
        int         pos;
        int         dig;
        int         w;
        bit         bnd;
        logic [3:0] eDis;
        logic [3:0] eAn;
        DataLoad  = ld;
        DataIn    = d;
        BlankMask = mask;
        @(posedge Clk);
        pos  = cyc % FRAME;
        dig  = pos / RD;
        w    = pos % RD;
        bnd  = (pos == FRAME - 1);
        eDis = 4'(showM >> (4 * dig));
        eAn  = 4'hF;
        if (w >= DEADC && !mask[dig]) eAn[dig] = 1'b0;
        if (bnd) begin
            if (ld) showM = d;
            else if (pendFM) showM = pendM;
            pendFM = 1'b0;
        end else if (ld) begin
            pendM  = d;
            pendFM = 1'b1;
        end
        cyc++;
        #1;
        chk("DisVal", 16'(DisVal), 16'(eDis));
        chk("AnOut", 16'(AnOut), 16'(eAn));
        chk("FrameDone", 16'(FrameDone), 16'(bnd));
        chk("Pending", 16'(Pending), 16'(pendFM));
        DataLoad = 1'b0;
    endtask

    // Idle until the next cycle sits at frame position p (bounded by a frame)
    task automatic runTo(input int p);
        for (int k = 0; k < FRAME; k++) begin
            if (cyc % FRAME == p) break;
            tick(1'b0, 16'h0);
        end
    endtask

    // Reset between edges, check immediate output clear, then first-anode delay
    task automatic midReset();
        int first;
        #2;
        Rst = 1'b1;
        #1;
        chk("RstAnOut", 16'(AnOut), 16'hF);
        chk("RstDisVal", 16'(DisVal), 16'h0);
        chk("RstPending", 16'(Pending), 16'h0);
        chk("RstFrameDone", 16'(FrameDone), 16'h0);
        modelReset();
        #2;
        Rst = 1'b0;
        first = -1;
        for (int k = 1; k <= 8; k++) begin
            tick(1'b0, 16'h0);
            if (first < 0 && AnOut == 4'b1110) first = k;
        end
        chk("FirstAnodeDelay", 16'(first), 16'd3);
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;
        Rst       = 1'b1;
        DataIn    = '0;
        DataLoad  = 1'b0;
        BlankMask = '0;
        mask      = '0;
        modelReset();

        // Power-on reset values
        repeat (2) @(posedge Clk);
        #1;
        chk("PorAnOut", 16'(AnOut), 16'hF);
        chk("PorDisVal", 16'(DisVal), 16'h0);
        chk("PorPending", 16'(Pending), 16'h0);
        chk("PorFrameDone", 16'(FrameDone), 16'h0);
        Rst = 1'b0;

        // Scan order
        tick(1'b1, 16'h3C5A);
        runTo(0);
        repeat (2 * FRAME) tick(1'b0, 16'h0);

        // Double buffer: load mid-frame at digit 1
        tick(1'b1, 16'h1234);
        runTo(0);
        runTo(RD);
        tick(1'b1, 16'hBEEF);
        runTo(0);
        repeat (FRAME) tick(1'b0, 16'h0);

        // Load exactly on the boundary with another value pending
        runTo(10);
        tick(1'b1, 16'hAAAA);
        runTo(FRAME - 1);
        tick(1'b1, 16'h0F0F);
        repeat (FRAME) tick(1'b0, 16'h0);

        // Overwrite within a frame
        runTo(3);
        tick(1'b1, 16'h1111);
        runTo(12);
        tick(1'b1, 16'h2222);
        runTo(0);
        repeat (FRAME) tick(1'b0, 16'h0);

        // Blanking
        mask = 4'b1010;
        repeat (2 * FRAME) tick(1'b0, 16'h0);
        mask = 4'b0000;

        // Random loads and mask changes
        repeat (400) begin
            mask = 4'($urandom);
            tick(($urandom % 8) == 0, 16'($urandom));
        end
        mask = 4'b0000;

        // Reset mid-scan with a value pending
        runTo(5);
        tick(1'b1, 16'h5555);
        runTo(13);
        midReset();
        repeat (FRAME + 8) tick(1'b0, 16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
